dest_reg_scoreboard: RTL and testbench

//  Consumes the destination-address select output of register stage 2 (rd_out_addr + rd_enable_ctrl).

---
 rtl/dest_reg_scoreboard_if.sv | 47 ++++
 rtl/dest_reg_scoreboard.sv | 91 +++++++++
 tb/tb_dest_reg_scoreboard.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dest_reg_scoreboard_if.sv
// dest_reg_scoreboard_if
//   Bundles the stage-2 issue signals and the scoreboard results between
//   register stage 2, the issue logic and the register-file write port.
//   master: issue-side driver (stage 2 / testbench)
//   slave : the scoreboard itself
// Signals
//   issue_valid  instruction present in stage 2
//   rd_enable    instruction writes a register
//   rd_addr      destination address (don't-care when rd_enable=0)
//   rs_addr      source register 1
//   rt_addr      source register 2
//   rs_used      rs is a true source
//   rt_used      rt is a true source
//   flush        squash the issuing instruction and pipe[0]
//   stall        RAW hazard, hold stage 2 (combinational)
//   wb_valid     register-file write strobe (registered)
//   wb_addr      register-file write address (registered)
//   pending_mask bit r set while any live entry targets register r
interface dest_reg_scoreboard_if #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
);
  logic              issue_valid;
  logic              rd_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_used;
  logic              rt_used;
  logic              flush;
  logic              stall;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [NUM_REGS-1:0] pending_mask;

  modport master (
    output issue_valid, rd_enable, rd_addr, rs_addr, rt_addr,
           rs_used, rt_used, flush,
    input  stall, wb_valid, wb_addr, pending_mask
  );

  modport slave (
    input  issue_valid, rd_enable, rd_addr, rs_addr, rt_addr,
           rs_used, rt_used, flush,
    output stall, wb_valid, wb_addr, pending_mask
  );
endinterface

// File: rtl/dest_reg_scoreboard.sv
// dest_reg_scoreboard
//   Tracks in-flight destination-register writes in a fixed-latency shadow
//   pipeline, raises a RAW-hazard stall to the issue logic and produces the
//   register-file write-back strobe/address WB_LATENCY cycles after issue.
// Ports
//   clk    pipeline clock, rising edge
//   reset  synchronous reset, active-high; discards all in-flight writes
//   bus    dest_reg_scoreboard_if.slave (issue inputs, stall/wb/pending outputs)
// Build option
//   WB_BYPASS_EN  defined: register file is write-before-read, so the
//                 write-back stage (pipe[WB_LATENCY-1]) does not cause stalls.
//                 undefined: every pipe stage participates in hazard matching.
module dest_reg_scoreboard #(
  parameter int WB_LATENCY = 3,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 32
) (
  input logic clk,
  input logic reset,
  dest_reg_scoreboard_if.slave bus
);

`ifdef WB_BYPASS_EN
  localparam int MATCH_N = WB_LATENCY - 1;
`else
  localparam int MATCH_N = WB_LATENCY;
`endif

  logic [WB_LATENCY-1:0] pipe_valid;
  logic [ADDR_W-1:0]     pipe_addr [WB_LATENCY];

  logic rs_hit;
  logic rt_hit;
  logic stall;
  logic accept;
  logic [NUM_REGS-1:0] pending;

  // Hazard match against live entries; register 0 never matches.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < MATCH_N; i++) begin
      if (pipe_valid[i] && (pipe_addr[i] == bus.rs_addr)) rs_hit = 1'b1;
      if (pipe_valid[i] && (pipe_addr[i] == bus.rt_addr)) rt_hit = 1'b1;
    end
    if (bus.rs_addr == '0) rs_hit = 1'b0;
    if (bus.rt_addr == '0) rt_hit = 1'b0;
  end

  assign stall  = bus.issue_valid & ~bus.flush &
                  ((bus.rs_used & rs_hit) | (bus.rt_used & rt_hit));

  // rd_enable gates first so an undriven rd_addr cannot leak into accept.
  assign accept = bus.issue_valid & bus.rd_enable & ~stall & ~bus.flush &
                  (bus.rd_enable ? (bus.rd_addr != '0) : 1'b0);

  always_comb begin
    pending = '0;
    for (int i = 0; i < WB_LATENCY; i++) begin
      if (pipe_valid[i]) pending[pipe_addr[i]] = 1'b1;
    end
  end

  // Shadow pipe shifts every cycle. Bubbles carry address 0 so wb_addr
  // stays clean whenever wb_valid is low. A flush kills both the incoming
  // instruction and the entry currently in pipe[0].
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < WB_LATENCY; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_addr[0]  <= accept ? bus.rd_addr : '0;
      for (int i = 1; i < WB_LATENCY; i++) begin
        if (i == 1) begin
          pipe_valid[i] <= pipe_valid[0] & ~bus.flush;
          pipe_addr[i]  <= bus.flush ? '0 : pipe_addr[0];
        end else begin
          pipe_valid[i] <= pipe_valid[i-1];
          pipe_addr[i]  <= pipe_addr[i-1];
        end
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.wb_valid     = pipe_valid[WB_LATENCY-1];
  assign bus.wb_addr      = pipe_addr[WB_LATENCY-1];
  assign bus.pending_mask = pending;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// tb_dest_reg_scoreboard
//   Scoreboard bench for dest_reg_scoreboard (WB_LATENCY=3). Each accepted
//   issue pushes {addr, due cycle} into a queue; the queue contents give the
//   expected stall and pending_mask, and entries are popped and compared when
//   their write-back cycle arrives. Honours WB_BYPASS_EN like the design.
module tb_dest_reg_scoreboard;
  localparam int L  = 3;
  localparam int AW = 5;
  localparam int NR = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_reg_scoreboard_if #(.ADDR_W(AW), .NUM_REGS(NR)) bus ();

  dest_reg_scoreboard #(.WB_LATENCY(L), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } wb_t;

  wb_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc   = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Queue entries at check time all sit in pipe[0..L-1]; due==cyc is the
  // write-back stage, excluded from hazards in the bypass build.
  function automatic bit model_match(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    foreach (exp_q[i]) begin
      if (!(BYP && exp_q[i].due == cyc) && exp_q[i].addr == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive(input bit iv, input bit rde, input int rd, input int rs,
                       input int rt, input bit rsu, input bit rtu, input bit fl);
    bus.issue_valid = iv;
    bus.rd_enable   = rde;
    bus.rd_addr     = AW'(rd);
    bus.rs_addr     = AW'(rs);
    bus.rt_addr     = AW'(rt);
    bus.rs_used     = rsu;
    bus.rt_used     = rtu;
    bus.flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    bit            st;
    bit            acc;
    bit            fl;
    logic [NR-1:0] pm;
    logic [AW-1:0] rda;
    @(negedge clk);
    st = bus.issue_valid && !bus.flush &&
         ((bus.rs_used && model_match(bus.rs_addr)) ||
          (bus.rt_used && model_match(bus.rt_addr)));
    pm = '0;
    foreach (exp_q[i]) pm[exp_q[i].addr] = 1'b1;
    if (chk_en) begin
      chk("stall", 32'(bus.stall), 32'(st));
      chk("pending_mask", 32'(bus.pending_mask), 32'(pm));
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (chk_en) begin
        chk("wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("wb_addr", 32'(bus.wb_addr), 32'(exp_q[0].addr));
      end
      void'(exp_q.pop_front());
    end else if (chk_en) begin
      chk("wb_idle", 32'(bus.wb_valid), 32'd0);
    end
    rda = bus.rd_addr;
    fl  = bus.flush;
    acc = bus.issue_valid && bus.rd_enable && (rda != '0) && !st && !fl;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
    end else begin
      if (fl && L > 1) begin
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].due == cyc + L - 1) exp_q.delete(i);
      end
      if (acc) exp_q.push_back('{addr: rda, due: cyc + L});
    end
    cyc++;
    #1;
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) begin
      idle();
      step();
    end
  endtask

  initial begin
    // Reset held two cycles with random inputs
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1));
      step();
      chk_en = 1'b1;
    end
    chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_pending", 32'(bus.pending_mask), 32'd0);
    reset = 1'b0;
    run_idle(1);

    // RAW on r5 with the consumer held in stage 2
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 5, 0, 1, 0, 0);
      step();
    end
    run_idle(2);

    // Writes to r0 are never tracked
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    step();
    run_idle(3);

    // Flush alongside issue of r7, then a read of r7
    drive(1, 1, 7, 0, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 7, 7, 1, 1, 0);
    step();
    run_idle(3);

    // Flush squashing the entry already in pipe[0]
    drive(1, 1, 10, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 11, 0, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 10, 11, 1, 1, 0);
    step();
    run_idle(4);

    // Back-to-back duplicate writes to r9
    drive(1, 1, 9, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 9, 0, 0, 0, 0, 0);
    step();
    run_idle(5);

    // Reset mid-flight discards r12
    drive(1, 1, 12, 0, 0, 0, 0, 0);
    step();
    run_idle(1);
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    run_idle(4);

    // Random traffic over a small register range to provoke hazards
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;
    run_idle(L + 2);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
